// File: rtl/spi_slave_rx.sv
// SPI mode-0 slave receiver: 16-bit command frames write 12-bit levels into an
// 8-entry channel bank; the previous valid frame is echoed on MISO.
// All SPI pins are asynchronous and oversampled on i_clk (clk >= 8x SCLK).
module spi_slave_rx #(
  parameter int unsigned FRAME_W  = 16,
  parameter int unsigned DATA_W   = 12,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned SYNC_LEN = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_sclk,
  input  logic              i_mosi,
  input  logic              i_cs_n,
  output logic              o_miso,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_wr_stb,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic              o_frame_err,
  output logic [7:0]        o_err_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam int unsigned CntW  = $clog2(FRAME_W + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(FRAME_W);
  localparam logic [CntW-1:0] CntSat  = CntW'(FRAME_W + 1);

  typedef enum logic [1:0] {StIdle, StShift, StCommit, StError} state_e;

  state_e r_state, w_state_nxt;

  logic [SYNC_LEN-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
  logic                r_sclk_d, r_cs_d;
  logic                w_sclk_s, w_mosi_s, w_cs_s;
  logic                w_sclk_rise, w_sclk_fall, w_cs_rise;

  logic [FRAME_W-1:0]  r_rx_sr, r_tx_sr, r_echo;
  logic [CntW-1:0]     r_bit_cnt;
  logic [DATA_W-1:0]   r_bank [Depth];

  logic                w_start, w_shift_en, w_commit, w_error, w_bank_we;
  logic [ADDR_W-1:0]   w_frame_addr;
  logic [DATA_W-1:0]   w_frame_data;

  assign w_sclk_s    = r_sclk_sync[SYNC_LEN-1];
  assign w_mosi_s    = r_mosi_sync[SYNC_LEN-1];
  assign w_cs_s      = r_cs_sync[SYNC_LEN-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
  assign w_cs_rise   = w_cs_s & ~r_cs_d;

  assign w_frame_addr = r_rx_sr[FRAME_W-2 -: ADDR_W];
  assign w_frame_data = r_rx_sr[DATA_W-1:0];

  // Synchronize SPI pins and keep one delayed copy for edge detection.
  // cs_n resets high so a released reset never looks like a frame start.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_LEN-2:0], i_sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_LEN-2:0], i_mosi};
      r_cs_sync   <= {r_cs_sync[SYNC_LEN-2:0], i_cs_n};
      r_sclk_d    <= w_sclk_s;
      r_cs_d      <= w_cs_s;
    end
  end

  // FSM state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= StIdle;
    else          r_state <= w_state_nxt;
  end

  // FSM next state. IDLE checks the cs_n level so a select that fell during
  // COMMIT/ERROR is still picked up on the return to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:   if (!w_cs_s) w_state_nxt = StShift;
      StShift:  if (w_cs_rise) w_state_nxt = (r_bit_cnt == CntFull) ? StCommit : StError;
      StCommit: w_state_nxt = StIdle;
      StError:  w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  // FSM outputs. A cs rise wins over an sclk edge in the same cycle.
  always_comb begin
    w_start    = (r_state == StIdle) && !w_cs_s;
    w_shift_en = (r_state == StShift) && !w_cs_rise;
    w_commit   = (r_state == StCommit);
    w_error    = (r_state == StError);
    w_bank_we  = w_commit && r_rx_sr[FRAME_W-1];
  end

  // Shift registers, bit counter and MISO driver.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rx_sr   <= '0;
      r_tx_sr   <= '0;
      r_bit_cnt <= '0;
      o_miso    <= 1'b0;
    end else if (w_start) begin
      r_bit_cnt <= '0;
      r_tx_sr   <= r_echo;
      o_miso    <= r_echo[FRAME_W-1];
    end else if (w_shift_en) begin
      if (w_sclk_rise) begin
        r_rx_sr <= {r_rx_sr[FRAME_W-2:0], w_mosi_s};
        if (r_bit_cnt != CntSat) r_bit_cnt <= r_bit_cnt + CntW'(1);
      end
      // Zeros shift in behind the echo, so MISO drops to 0 after bit 15.
      if (w_sclk_fall) begin
        r_tx_sr <= {r_tx_sr[FRAME_W-2:0], 1'b0};
        o_miso  <= r_tx_sr[FRAME_W-2];
      end
    end
  end

  // Commit / error bookkeeping: echo, channel bank, strobes and error count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_echo      <= '0;
      o_wr_stb    <= 1'b0;
      o_wr_addr   <= '0;
      o_frame_err <= 1'b0;
      o_err_cnt   <= '0;
      for (int i = 0; i < Depth; i++) r_bank[i] <= '0;
    end else begin
      o_wr_stb    <= w_bank_we;
      o_frame_err <= w_error;
      if (w_commit) r_echo <= r_rx_sr;
      if (w_bank_we) begin
        r_bank[w_frame_addr] <= w_frame_data;
        o_wr_addr            <= w_frame_addr;
      end
      if (w_error && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 8'd1;
    end
  end

  // Registered bank read port; a same-cycle write shows up one clock later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_rd_data <= '0;
    else          o_rd_data <= r_bank[i_rd_addr];
  end

endmodule
